keypad_scan_debounce: RTL and testbench

//  Scans the 4x4 matrix keypad and debounces it. Emits one 4-bit key code per press

---
 rtl/keypad_pkg.sv | 23 ++
 rtl/keypad_tick_gen.sv | 30 +++
 rtl/keypad_scan_debounce.sv | 196 +++++++++++++++++++
 tb/tb_keypad_scan_debounce.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types, key-code aliases and helpers for the keypad scanner.
// Revision: 1.0
`default_nettype none

package keypad_pkg;

  typedef enum logic [1:0] {KP_IDLE, KP_DEB_ON, KP_HELD, KP_DEB_OFF} kp_state_t;

  typedef logic [3:0] kp_code_t;

  localparam kp_code_t KP_LEFT  = 4'd15;
  localparam kp_code_t KP_RIGHT = 4'd3;
  localparam kp_code_t KP_DOWN  = 4'd2;
  localparam kp_code_t KP_ROT_L = 4'd11;
  localparam kp_code_t KP_ROT_R = 4'd7;

  function automatic logic [2:0] kp_popcount4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_tick_gen.sv
// keypad_tick_gen: free-running prescaler, one-cycle tick every TICK_DIV clocks.
// Revision: 1.0
`default_nettype none

module keypad_tick_gen
  import keypad_pkg::*;
#(
  parameter int TICK_DIV = 50_000
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic tick_o
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  assign tick_o = (cnt_q == CNT_TERM);
  assign cnt_d  = tick_o ? '0 : cnt_q + CNT_W'(1);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/keypad_scan_debounce.sv
// keypad_scan_debounce: 4x4 matrix scanner with scan-level debounce and a valid/ack event register.
// Revision: 1.0
`default_nettype none

module keypad_scan_debounce
  import keypad_pkg::*;
#(
  parameter int TICK_DIV       = 50_000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic [3:0] KEYPAD_ROWS,
  output logic [3:0] KEYPAD_COLS,
  output kp_code_t   KEY_CODE,
  output logic       KEY_VALID,
  input  logic       KEY_ACK,
  output logic       PRESSED,
  output logic       OVERRUN,
  input  logic       OVERRUN_CLR
);

  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic tick;

  keypad_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk_i  (CLK),
    .rst_ni (RESET_N),
    .tick_o (tick)
  );

  // Scan accumulator: hit count saturates at 2 so multi-key scans read as NONE.
  logic [1:0] col_q, col_d;
  logic [1:0] hits_q, hits_d;
  kp_code_t   pos_q, pos_d;
  logic [3:0] row_hits;
  logic [2:0] pop, hits_sum;
  logic [1:0] row_idx, hits_base;
  kp_code_t   pos_base;
  logic       scan_done, res_valid;

  assign KEYPAD_COLS = ~(4'b0001 << col_q);
  assign row_hits    = ~KEYPAD_ROWS;
  assign pop         = kp_popcount4(row_hits);
  assign scan_done   = tick && (col_q == 2'd3);

  always_comb begin
    row_idx = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (row_hits[r]) row_idx = 2'(r);
    end
  end

  always_comb begin
    hits_base = (col_q == 2'd0) ? 2'd0 : hits_q;
    pos_base  = (col_q == 2'd0) ? '0 : pos_q;
    hits_sum  = 3'(hits_base) + pop;
    hits_d    = (hits_sum >= 3'd2) ? 2'd2 : hits_sum[1:0];
    pos_d     = (hits_base == 2'd0 && pop == 3'd1) ? {col_q, row_idx} : pos_base;
    col_d     = col_q + 2'd1;
  end

  assign res_valid = scan_done && (hits_d == 2'd1);

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      col_q  <= 2'd0;
      hits_q <= 2'd0;
      pos_q  <= '0;
    end else if (tick) begin
      col_q  <= col_d;
      hits_q <= hits_d;
      pos_q  <= pos_d;
    end
  end

  // Debounce FSM, advanced only on the cycle that closes a scan.
  kp_state_t        state_q, state_d;
  kp_code_t         cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             match, emit;

  assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
  assign match   = res_valid && (pos_d == cand_q);

  always_comb begin
    state_d = state_q;
    cand_d  = cand_q;
    cnt_d   = cnt_q;
    emit    = 1'b0;
    if (scan_done) begin
      case (state_q)
        KP_IDLE: begin
          if (res_valid) begin
            cand_d = pos_d;
            cnt_d  = CNT_ONE;
            if (CNT_ONE == CNT_MAX) begin
              state_d = KP_HELD;
              emit    = 1'b1;
            end else begin
              state_d = KP_DEB_ON;
            end
          end
        end
        KP_DEB_ON: begin
          if (match) begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_d = KP_HELD;
              emit    = 1'b1;
            end
          end else begin
            state_d = KP_IDLE;
            cnt_d   = '0;
          end
        end
        KP_HELD: begin
          if (!match) begin
            cnt_d   = CNT_ONE;
            state_d = (CNT_ONE == CNT_MAX) ? KP_IDLE : KP_DEB_OFF;
          end
        end
        KP_DEB_OFF: begin
          if (match) begin
            state_d = KP_HELD;
          end else begin
            cnt_d = cnt_inc;
            if (cnt_inc == CNT_MAX) begin
              state_d = KP_IDLE;
              cnt_d   = '0;
            end
          end
        end
        default: begin
          state_d = KP_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q <= KP_IDLE;
      cand_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      cnt_q   <= cnt_d;
    end
  end

  // Event register: an ack in the emit cycle frees the slot for the new code.
  kp_code_t code_q, code_d;
  logic     valid_q, valid_d;
  logic     ovr_q, ovr_d;
  logic     drop;

  assign drop = emit && valid_q && !KEY_ACK;

  always_comb begin
    code_d  = code_q;
    valid_d = valid_q;
    if (emit && !drop) begin
      code_d  = cand_q;
      valid_d = 1'b1;
    end else if (KEY_ACK) begin
      valid_d = 1'b0;
    end
    ovr_d = drop ? 1'b1 : (OVERRUN_CLR ? 1'b0 : ovr_q);
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      code_q  <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      code_q  <= code_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign KEY_CODE  = code_q;
  assign KEY_VALID = valid_q;
  assign OVERRUN   = ovr_q;
  assign PRESSED   = (state_q == KP_HELD) || (state_q == KP_DEB_OFF);

endmodule

`default_nettype wire

// File: tb/tb_keypad_scan_debounce.sv
// tb_keypad_scan_debounce: directed bench with a behavioural 4x4 keypad model.
// Revision: 1.0
`default_nettype none

module tb_keypad_scan_debounce;

  localparam int TICK_DIV       = 4;
  localparam int DEBOUNCE_SCANS = 3;
  localparam int SCAN_CLKS      = 4 * TICK_DIV;

  logic       clk;
  logic       rst_n;
  logic [3:0] rows;
  logic [3:0] cols;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack;
  logic       pressed;
  logic       overrun;
  logic       overrun_clr;

  logic [15:0] keys;
  int          n_chk;
  int          n_bad;
  int          n_ev;
  int          e0;
  logic        prev_v;

  keypad_scan_debounce #(
    .TICK_DIV       (TICK_DIV),
    .DEBOUNCE_SCANS (DEBOUNCE_SCANS)
  ) dut (
    .CLK         (clk),
    .RESET_N     (rst_n),
    .KEYPAD_ROWS (rows),
    .KEYPAD_COLS (cols),
    .KEY_CODE    (key_code),
    .KEY_VALID   (key_valid),
    .KEY_ACK     (key_ack),
    .PRESSED     (pressed),
    .OVERRUN     (overrun),
    .OVERRUN_CLR (overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Pulled-up rows; a held key shorts its row to the column driven low.
  always_comb begin
    rows = 4'hF;
    for (int c = 0; c < 4; c++) begin
      if (!cols[c]) begin
        for (int r = 0; r < 4; r++) begin
          if (keys[c*4 + r]) rows[r] = 1'b0;
        end
      end
    end
  end

  initial begin
    n_ev   = 0;
    prev_v = 1'b0;
  end

  always @(posedge clk) begin
    #1;
    if (key_valid && !prev_v) n_ev++;
    prev_v = key_valid;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic scans(input int n);
    repeat (n * SCAN_CLKS) @(negedge clk);
  endtask

  task automatic ack_pulse();
    key_ack = 1'b1;
    @(negedge clk);
    key_ack = 1'b0;
    chk("ack_clears_valid", 32'(key_valid), 32'd0);
    repeat (SCAN_CLKS - 1) @(negedge clk);
  endtask

  initial begin
    logic [3:0] exp_cols;
    n_chk       = 0;
    n_bad       = 0;
    rst_n       = 1'b0;
    keys        = '0;
    key_ack     = 1'b0;
    overrun_clr = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_cols", 32'(cols), 32'hE);
    chk("rst_code", 32'(key_code), 32'd0);
    chk("rst_valid", 32'(key_valid), 32'd0);
    chk("rst_pressed", 32'(pressed), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst_n = 1'b1;

    // 1: idle column rotation
    for (int i = 0; i < 16; i++) begin
      exp_cols = ~(4'b0001 << (i / 4));
      chk("idle_cols", 32'(cols), 32'(exp_cols));
      @(negedge clk);
    end
    chk("idle_valid", 32'(key_valid), 32'd0);
    chk("idle_pressed", 32'(pressed), 32'd0);

    // 2: clean press of key 11
    e0 = n_ev;
    keys[11] = 1'b1;
    scans(2);
    chk("k11_not_yet", 32'(key_valid), 32'd0);
    scans(1);
    chk("k11_valid", 32'(key_valid), 32'd1);
    chk("k11_code", 32'(key_code), 32'd11);
    chk("k11_pressed", 32'(pressed), 32'd1);
    scans(2);
    chk("k11_one_event", 32'(n_ev - e0), 32'd1);
    ack_pulse();
    keys = '0;
    scans(2);
    chk("k11_still_pressed", 32'(pressed), 32'd1);
    scans(1);
    chk("k11_released", 32'(pressed), 32'd0);
    chk("k11_no_repeat", 32'(n_ev - e0), 32'd1);

    // 3: bouncing key 3 then stable
    e0 = n_ev;
    for (int k = 0; k < 3; k++) begin
      keys[3] = 1'b1;
      scans(1);
      keys[3] = 1'b0;
      scans(1);
    end
    chk("bounce_no_event", 32'(n_ev - e0), 32'd0);
    keys[3] = 1'b1;
    scans(2);
    chk("bounce_not_yet", 32'(key_valid), 32'd0);
    scans(1);
    chk("bounce_valid", 32'(key_valid), 32'd1);
    chk("bounce_code", 32'(key_code), 32'd3);
    chk("bounce_one_event", 32'(n_ev - e0), 32'd1);
    ack_pulse();
    keys = '0;
    scans(3);

    // 4: overrun
    keys[15] = 1'b1;
    scans(3);
    chk("k15_code", 32'(key_code), 32'd15);
    keys = '0;
    scans(3);
    chk("k15_released", 32'(pressed), 32'd0);
    keys[2] = 1'b1;
    scans(2);
    chk("ovr_not_yet", 32'(overrun), 32'd0);
    scans(1);
    chk("ovr_set", 32'(overrun), 32'd1);
    chk("ovr_code_kept", 32'(key_code), 32'd15);
    chk("ovr_valid", 32'(key_valid), 32'd1);
    chk("ovr_pressed", 32'(pressed), 32'd1);
    overrun_clr = 1'b1;
    @(negedge clk);
    overrun_clr = 1'b0;
    chk("ovr_cleared", 32'(overrun), 32'd0);
    repeat (SCAN_CLKS - 1) @(negedge clk);
    keys = '0;
    scans(3);
    ack_pulse();
    chk("ovr_code_after_ack", 32'(key_code), 32'd15);

    // 5: two keys rejected, then single key 5
    e0 = n_ev;
    keys[5] = 1'b1;
    keys[6] = 1'b1;
    scans(4);
    chk("multi_no_event", 32'(n_ev - e0), 32'd0);
    chk("multi_pressed", 32'(pressed), 32'd0);
    keys[6] = 1'b0;
    scans(2);
    chk("k5_not_yet", 32'(key_valid), 32'd0);
    scans(1);
    chk("k5_valid", 32'(key_valid), 32'd1);
    chk("k5_code", 32'(key_code), 32'd5);
    chk("k5_one_event", 32'(n_ev - e0), 32'd1);
    ack_pulse();
    keys = '0;
    scans(3);

    // 6: async reset mid-debounce and while valid
    keys[7] = 1'b1;
    scans(1);
    repeat (5) @(negedge clk);
    chk("pre_rst_cols", 32'(cols), 32'hD);
    #2 rst_n = 1'b0;
    #1;
    chk("arst1_cols", 32'(cols), 32'hE);
    chk("arst1_valid", 32'(key_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    scans(2);
    chk("arst1_cnt_cleared", 32'(key_valid), 32'd0);
    scans(1);
    chk("k7_valid", 32'(key_valid), 32'd1);
    chk("k7_code", 32'(key_code), 32'd7);
    repeat (6) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst2_cols", 32'(cols), 32'hE);
    chk("arst2_code", 32'(key_code), 32'd0);
    chk("arst2_valid", 32'(key_valid), 32'd0);
    chk("arst2_pressed", 32'(pressed), 32'd0);
    chk("arst2_overrun", 32'(overrun), 32'd0);
    @(negedge clk);
    keys  = '0;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
